spi_txn_arbiter: RTL
====================

SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

Interface
REQ-001 SHALL have parameter FRAME_CYCLES, default 16, meaning SPI frame length in m_clk cycles (8 address + 8 data bits); legal range 2..255.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, meaning idle cycles between frames; legal range 2..15.
REQ-003 SHALL have port m_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port n_reset  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have ports req0, req1  input  1  requester level request; held high until ack.
REQ-006 SHALL have ports rnw0, rnw1  input  1  1 = read, 0 = write.
REQ-007 SHALL have ports addr0, addr1  input  8  target address byte.
REQ-008 SHALL have ports ack0, ack1  output  1  one-cycle completion pulse to the owning requester.
REQ-009 SHALL have port read_request  output  1  one-cycle start pulse to control_unit for a read.
REQ-010 SHALL have port data_available  output  1  one-cycle start pulse to control_unit for a write.
REQ-011 SHALL have port add_byte  output  8  latched address driven to control_unit.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port owner  output  1  index of the current or most recent grantee.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, FRAME, GAP.
REQ-015 IDLE: request inputs SHALL be sampled only in IDLE; if any req is high, the FSM SHALL latch the winner's addr, rnw and index and go to ISSUE next cycle.
REQ-016 Simultaneous req0 and req1 SHALL be resolved round-robin: the requester not granted last wins; after reset, requester 0 wins.
REQ-017 Single requester SHALL win regardless of pointer; the pointer SHALL update only at ack.
REQ-018 ISSUE SHALL last exactly 1 cycle: read_request high if latched rnw = 1, else data_available high; never both.
REQ-019 FRAME SHALL last exactly FRAME_CYCLES cycles, counted by a down-counter loaded on ISSUE entry.
REQ-020 GAP SHALL last exactly GAP_CYCLES cycles, then return to IDLE; ack[owner] SHALL be high only in the first GAP cycle.
REQ-021 Latency: req sampled in IDLE at cycle k gives ISSUE at k+1, FRAME at k+2..k+1+FRAME_CYCLES, ack at k+2+FRAME_CYCLES, IDLE at k+2+FRAME_CYCLES+GAP_CYCLES.
REQ-022 add_byte SHALL hold the latched address from ISSUE until the next grant latches a new one.
REQ-023 Changes to addr/rnw after latch, or req deasserted mid-transaction, SHALL be ignored; the transaction SHALL complete and ack SHALL still pulse.
REQ-024 Requests SHALL NOT be sampled during ISSUE, FRAME or GAP; a requester dropping req within GAP_CYCLES-1 cycles after ack SHALL NOT be re-granted.
REQ-025 Back-to-back: a pending req from the other requester SHALL be granted in the first IDLE cycle after GAP.

Reset
REQ-026 While n_reset = 0: state IDLE; read_request, data_available, ack0, ack1, busy, owner = 0; add_byte = 0x00; counter 0; round-robin pointer favours requester 0.
REQ-027 Reset asserted mid-transaction SHALL abort immediately with no ack pulse; after release the first grant SHALL follow REQ-015 from IDLE.

Structure
REQ-028 Shared package spi_arb_pkg SHALL hold the state encoding and default FRAME_CYCLES/GAP_CYCLES constants.
REQ-029 One sub-module spi_frame_counter (loadable 8-bit down-counter with zero flag) SHALL time FRAME and GAP.

Verification
REQ-030 Reset: n_reset pulsed low mid-FRAME -> all outputs 0 within the same cycle, no ack, busy = 0.
REQ-031 Single read: req0 = 1, rnw0 = 1, addr0 = 0xA5 -> read_request pulse 1 cycle, add_byte = 0xA5, ack0 exactly 18 cycles after the sample edge (defaults), data_available never high.
REQ-032 Contention: req0 and req1 both high from reset release -> grant order 0, 1, 0, 1; each ack to the correct index; 20-cycle period per transaction.
REQ-033 Write: req1 = 1, rnw1 = 0, addr1 = 0x3C -> data_available pulse only, owner = 1, ack1 once.
REQ-034 Withdrawal: req0 dropped 3 cycles into FRAME -> ack0 still pulses; no second grant; busy falls after GAP.
REQ-035 Mid-transaction addr0 change 0x11 -> 0x22 -> add_byte stays 0x11 until ack.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared definitions for the two-requester SPI transaction arbiter:
// FSM state encoding and default frame/gap timing.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_FRAME = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_t;

    localparam int DEF_FRAME_CYCLES = 16;
    localparam int DEF_GAP_CYCLES   = 2;

endpackage

// File: rtl/spi_frame_counter.sv
// Loadable 8-bit down-counter with zero flag; times both the FRAME and GAP
// phases of the arbiter. Saturates at zero.
module spi_frame_counter (
    input  logic       m_clk,
    input  logic       n_reset,
    input  logic       load,
    input  logic       dec,
    input  logic [7:0] load_val,
    output logic       zero
);

    logic [7:0] cnt;

    always_ff @(posedge m_clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !zero) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign zero = (cnt == 8'd0);

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter granting one of two requesters a single SPI frame
// on the shared control_unit, with a fixed idle gap between frames.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | sample req0/req1, latch winner's addr/rnw/index
// ST_ISSUE | one-cycle read_request or data_available pulse
// ST_FRAME | FRAME_CYCLES cycles while the frame is shifted out
// ST_GAP   | GAP_CYCLES idle cycles; ack to owner in the first one
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic       m_clk,
    input  logic       n_reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       rnw0,
    input  logic       rnw1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    output logic       ack0,
    output logic       ack1,
    output logic       read_request,
    output logic       data_available,
    output logic [7:0] add_byte,
    output logic       busy,
    output logic       owner
);

    // Counter runs to zero inclusive, so load one less than the phase length.
    localparam logic [7:0] FRAME_LOAD = 8'(FRAME_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

    arb_state_t state;
    logic       rr_prio;
    logic       any_req;
    logic       win;
    logic       win_rnw;
    logic       cnt_load;
    logic       cnt_dec;
    logic [7:0] cnt_load_val;
    logic       cnt_zero;

    assign any_req = req0 || req1;
    assign win     = (req0 && req1) ? rr_prio : req1;
    assign win_rnw = win ? rnw1 : rnw0;

    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = FRAME_LOAD;
        cnt_dec      = 1'b0;
        case (state)
            ST_IDLE:  cnt_load = any_req;
            ST_FRAME: begin
                cnt_dec      = 1'b1;
                cnt_load     = cnt_zero;
                cnt_load_val = GAP_LOAD;
            end
            ST_GAP:   cnt_dec = 1'b1;
            default:  cnt_load = 1'b0;
        endcase
    end

    spi_frame_counter u_frame_counter (
        .m_clk    (m_clk),
        .n_reset  (n_reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge m_clk or negedge n_reset) begin
        if (!n_reset) begin
            state          <= ST_IDLE;
            read_request   <= 1'b0;
            data_available <= 1'b0;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            busy           <= 1'b0;
            owner          <= 1'b0;
            add_byte       <= 8'h00;
            rr_prio        <= 1'b0;
        end else begin
            read_request   <= 1'b0;
            data_available <= 1'b0;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state          <= ST_ISSUE;
                        busy           <= 1'b1;
                        owner          <= win;
                        add_byte       <= win ? addr1 : addr0;
                        read_request   <= win_rnw;
                        data_available <= !win_rnw;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_FRAME;
                end
                ST_FRAME: begin
                    if (cnt_zero) begin
                        state   <= ST_GAP;
                        ack0    <= !owner;
                        ack1    <= owner;
                        // Pointer moves only on completion: the other side wins next tie.
                        rr_prio <= !owner;
                    end
                end
                ST_GAP: begin
                    if (cnt_zero) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
